vga_char_fetch: RTL and testbench
=================================

VGA_CHAR_FETCH -- requirements
Module: vga_char_fetch

Interface
REQ-001 SHALL have parameter TXT_COLS, default 80, text columns per row.
REQ-002 SHALL have parameter TXT_ROWS, default 30, text rows per frame.
REQ-003 SHALL have one clock and one reset: i_clk is the single clock; the reset is asynchronous and active-low, named i_rst_n.
REQ-004 SHALL have the following ports:
- i_clk  in  1  pixel clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_line_start  in  1  one-cycle pulse; at least 8 cycles before the first active pixel of a scanline.
- i_row  in  5  text row, sampled on i_line_start.
- i_font_line  in  4  glyph line 0..15, sampled on i_line_start.
- i_de  in  1  active-video enable.
- o_txt_addr  out  12  text RAM address.
- i_txt_data  in  8  character code; valid 1 cycle after o_txt_addr.
- o_font_addr  out  12  font ROM address, {char[7:0], font_line[3:0]}.
- i_font_data  in  8  glyph row, MSB = leftmost pixel; valid 1 cycle after o_font_addr.
- o_sh_data  out  8  glyph byte to the shift register.
- o_sh_ld  out  1  shift-register load strobe.
- o_sh_cs  out  1  shift-register chip select.
- o_underrun  out  1  sticky: a load occurred with no fetched data.

Function
REQ-005 SHALL keep a 3-bit cell phase: cleared while i_de=0, incremented every cycle while i_de=1, wrapping 7->0.
REQ-006 SHALL assert o_sh_ld exactly when i_de=1 and phase=0, i.e. the first cycle of each 8-pixel cell.
REQ-007 SHALL drive o_sh_cs = i_de OR i_de delayed by 1 cycle; downstream pixels lag i_de by 1 cycle, and the sync generator matches that delay.
REQ-008 SHALL hold o_sh_data from a one-entry buffer with a valid flag FULL; o_sh_data is stable whenever FULL=1.
REQ-009 SHALL run a fetch FSM with states IDLE, T_RD, T_WAIT, F_RD, F_WAIT:
- IDLE->T_RD when the fetch is enabled, FULL=0 and col<TXT_COLS.
- T_RD: drive o_txt_addr = base+col.
- T_WAIT: capture i_txt_data.
- F_RD: drive o_font_addr.
- F_WAIT: capture i_font_data into the buffer, set FULL, col+1, then go to IDLE.
REQ-010 SHALL produce fetch latency from FULL clearing to FULL setting of at most 5 cycles, which is shorter than one cell.
REQ-011 SHALL clear FULL on each o_sh_ld; the FSM starts the next fetch in the following cycle.
REQ-012 SHALL, on o_sh_ld with FULL=0, set o_underrun (cleared only by reset) and present o_sh_data=0x00 for that cell.
REQ-013 SHALL, on i_line_start:
- compute base = i_row*TXT_COLS using shift-add ((row<<6)+(row<<4) for 80);
- clear col and FULL;
- latch i_font_line;
- abort any in-flight fetch and return to IDLE, with fetch enabled.
REQ-014 SHALL stop fetching after col reaches TXT_COLS; the FSM stays in IDLE until the next i_line_start.
REQ-015 SHALL give i_line_start priority if it coincides with o_sh_ld; no underrun is flagged for that cycle.
REQ-016 SHALL treat i_row >= TXT_ROWS as row TXT_ROWS-1 (clamp), so o_txt_addr never exceeds TXT_COLS*TXT_ROWS-1.
REQ-017 SHALL hold o_txt_addr and o_font_addr at their last values outside T_RD and F_RD.

Reset
REQ-018 SHALL, while i_rst_n=0, drive all outputs to 0, with FSM=IDLE, fetch disabled, phase=0, col=0, base=0 and FULL=0.
REQ-019 SHALL, when reset asserts mid-fetch or mid-line, take effect immediately (asynchronous); after release, no load or fetch occurs before the next i_line_start.

Structure
REQ-020 SHALL place TXT_COLS/TXT_ROWS defaults, FONT_H=16, the cell width 8 and the FSM state encoding in shared package vga_txt_pkg.
REQ-021 SHALL be a single module with no sub-modules; the downstream 8-bit shift register is instantiated by the parent.

Verification
REQ-022 SHALL cover: line_start with row=2, font_line=5, then 16 i_de cycles -> first o_txt_addr=160, o_font_addr={i_txt_data,4'h5}, o_sh_ld at de cycles 0 and 8.
REQ-023 SHALL cover: text RAM holds 0x41 at address 0, font ROM holds 0x18 at 0x415; row=0, font_line=5 -> o_sh_data=0x18 at the first o_sh_ld.
REQ-024 SHALL cover: a full line of 640 de cycles -> exactly 80 fetches and 80 loads; last o_txt_addr=base+79; no fetch after col=80; o_underrun=0.
REQ-025 SHALL cover: i_de raised 2 cycles after i_line_start -> first load sees FULL=0, o_underrun=1 and o_sh_data=0x00.
REQ-026 SHALL cover: i_rst_n low during F_WAIT -> all outputs 0 immediately; after release and before the next line_start, no o_sh_ld and no address change.
REQ-027 SHALL cover: i_row=31 -> o_txt_addr base=2320 (clamped to row 29).

Source files
------------

// File: rtl/vga_txt_pkg.sv
// Shared constants and fetch FSM encoding for the VGA text-mode character fetcher.
// row_base() builds row*cols from shifted copies of row, one per set bit of cols.
package vga_txt_pkg;

    localparam int TXT_COLS_DEF = 80;
    localparam int TXT_ROWS_DEF = 30;
    localparam int FONT_H       = 16;
    localparam int CELL_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_T_RD   = 3'd1,
        ST_T_WAIT = 3'd2,
        ST_F_RD   = 3'd3,
        ST_F_WAIT = 3'd4
    } fetch_st_e;

    // For cols=80 this reduces to (row<<6)+(row<<4).
    function automatic logic [11:0] row_base(input logic [4:0] row, input int cols);
        logic [11:0] acc;
        acc = '0;
        for (int k = 0; k < 12; k++) begin
            if (cols[k]) acc = acc + (12'(row) << k);
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_char_fetch.sv
// Text-mode character fetcher: per 8-pixel cell, reads the character code, then its
// glyph row, into a one-entry buffer that feeds the downstream shift register.
module vga_char_fetch
    import vga_txt_pkg::*;
#(
    parameter int TXT_COLS = TXT_COLS_DEF,
    parameter int TXT_ROWS = TXT_ROWS_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_line_start,
    input  logic [4:0]  i_row,
    input  logic [3:0]  i_font_line,
    input  logic        i_de,
    output logic [11:0] o_txt_addr,
    input  logic [7:0]  i_txt_data,
    output logic [11:0] o_font_addr,
    input  logic [7:0]  i_font_data,
    output logic [7:0]  o_sh_data,
    output logic        o_sh_ld,
    output logic        o_sh_cs,
    output logic        o_underrun
);

    localparam int COL_W = $clog2(TXT_COLS + 1);
    localparam int PH_W  = $clog2(CELL_W);

    fetch_st_e          state_q, state_d;
    logic               line_en_q, line_en_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic               de_q;
    logic [COL_W-1:0]   col_q, col_d;
    logic [11:0]        base_q, base_d;
    logic [3:0]         fl_q, fl_d;
    logic [7:0]         buf_q, buf_d;
    logic               full_q, full_d;
    logic [11:0]        txt_addr_q, txt_addr_d;
    logic [11:0]        font_addr_q, font_addr_d;
    logic               underrun_q, underrun_d;
    logic               sh_ld;
    logic [4:0]         row_c;

    // Loads are gated by line_en_q so nothing reaches the shifter between reset and the first line.
    assign sh_ld = line_en_q & i_de & (phase_q == '0);
    assign row_c = (i_row >= 5'(TXT_ROWS)) ? 5'(TXT_ROWS - 1) : i_row;

    always_comb begin
        state_d     = state_q;
        line_en_d   = line_en_q;
        phase_d     = i_de ? phase_q + 1'b1 : '0;
        col_d       = col_q;
        base_d      = base_q;
        fl_d        = fl_q;
        buf_d       = buf_q;
        full_d      = full_q;
        txt_addr_d  = txt_addr_q;
        font_addr_d = font_addr_q;
        underrun_d  = underrun_q;

        if (sh_ld) begin
            full_d = 1'b0;
            if (!full_q) underrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (line_en_q && !full_q && col_q < COL_W'(TXT_COLS)) begin
                    state_d    = ST_T_RD;
                    txt_addr_d = base_q + 12'(col_q);
                end
            end
            ST_T_RD:   state_d = ST_T_WAIT;
            ST_T_WAIT: begin
                font_addr_d = {i_txt_data, fl_q};
                state_d     = ST_F_RD;
            end
            ST_F_RD:   state_d = ST_F_WAIT;
            ST_F_WAIT: begin
                buf_d   = i_font_data;
                full_d  = 1'b1;
                col_d   = col_q + 1'b1;
                state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase

        // A new line wins over everything, including a coincident load's underrun.
        if (i_line_start) begin
            base_d     = row_base(row_c, TXT_COLS);
            col_d      = '0;
            full_d     = 1'b0;
            fl_d       = i_font_line;
            state_d    = ST_IDLE;
            line_en_d  = 1'b1;
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            line_en_q   <= 1'b0;
            phase_q     <= '0;
            de_q        <= 1'b0;
            col_q       <= '0;
            base_q      <= '0;
            fl_q        <= '0;
            buf_q       <= '0;
            full_q      <= 1'b0;
            txt_addr_q  <= '0;
            font_addr_q <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_en_q   <= line_en_d;
            phase_q     <= phase_d;
            de_q        <= i_de;
            col_q       <= col_d;
            base_q      <= base_d;
            fl_q        <= fl_d;
            buf_q       <= buf_d;
            full_q      <= full_d;
            txt_addr_q  <= txt_addr_d;
            font_addr_q <= font_addr_d;
            underrun_q  <= underrun_d;
        end
    end

    assign o_txt_addr  = txt_addr_q;
    assign o_font_addr = font_addr_q;
    assign o_sh_data   = full_q ? buf_q : 8'h00;
    assign o_sh_ld     = sh_ld;
    assign o_sh_cs     = line_en_q & (i_de | de_q);
    assign o_underrun  = underrun_q;

endmodule

// File: tb/tb_vga_char_fetch.sv
// Bench for vga_char_fetch: table of scanlines plus hand sequences for underrun,
// line_start/load collision and mid-fetch reset; glyph bytes checked via a scoreboard.
module tb_vga_char_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_line_start;
    logic [4:0]  i_row;
    logic [3:0]  i_font_line;
    logic        i_de;
    logic [11:0] o_txt_addr;
    logic [7:0]  i_txt_data;
    logic [11:0] o_font_addr;
    logic [7:0]  i_font_data;
    logic [7:0]  o_sh_data;
    logic        o_sh_ld;
    logic        o_sh_cs;
    logic        o_underrun;

    vga_char_fetch dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_line_start(i_line_start),
        .i_row(i_row), .i_font_line(i_font_line), .i_de(i_de),
        .o_txt_addr(o_txt_addr), .i_txt_data(i_txt_data),
        .o_font_addr(o_font_addr), .i_font_data(i_font_data),
        .o_sh_data(o_sh_data), .o_sh_ld(o_sh_ld), .o_sh_cs(o_sh_cs),
        .o_underrun(o_underrun)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] txt_mem  [4096];
    logic [7:0] font_mem [4096];

    // Synchronous RAM/ROM models: data valid one cycle after the address.
    always @(posedge i_clk) begin
        i_txt_data  <= txt_mem[o_txt_addr];
        i_font_data <= font_mem[o_font_addr];
    end

    int total = 0;
    int bad   = 0;
    int ld_cnt = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && o_sh_ld) begin
            ld_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_ld", 1, 0);
            end else begin
                check("sh_data", int'(o_sh_data), int'(exp_q.pop_front()));
            end
        end
    end

    function automatic int base_of(input int row);
        return ((row > 29) ? 29 : row) * 80;
    endfunction

    function automatic logic [7:0] glyph(input int base, input int c, input int fl);
        logic [11:0] a;
        a = 12'(base + c);
        return font_mem[{txt_mem[a], 4'(fl)}];
    endfunction

    task automatic push_line(input int row, input int fl, input int n, input bit ur_first);
        int b;
        b = base_of(row);
        for (int c = 0; c < n; c++) begin
            if (ur_first) exp_q.push_back((c == 0) ? 8'h00 : glyph(b, c - 1, fl));
            else          exp_q.push_back(glyph(b, c, fl));
        end
    endtask

    task automatic pulse_ls(input int row, input int fl);
        @(posedge i_clk);
        #1 i_row = 5'(row); i_font_line = 4'(fl); i_line_start = 1'b1;
        @(posedge i_clk);
        #1 i_line_start = 1'b0;
    endtask

    typedef struct {
        int row;
        int fl;
        int lead;
        int ncells;
        int exp_base;
    } vec_t;

    vec_t tbl [5];

    task automatic run_line(input vec_t v);
        int last;
        ld_cnt = 0;
        push_line(v.row, v.fl, v.ncells, 1'b0);
        pulse_ls(v.row, v.fl);
        repeat (v.lead - 2) @(posedge i_clk);
        @(negedge i_clk);
        check("first_txt_addr", int'(o_txt_addr), v.exp_base);
        check("first_font_addr", int'(o_font_addr),
              int'({txt_mem[12'(v.exp_base)], 4'(v.fl)}));
        @(posedge i_clk);
        #1 i_de = 1'b1;
        repeat (v.ncells * 8) @(posedge i_clk);
        #1 i_de = 1'b0;
        repeat (16) @(negedge i_clk);
        last = v.exp_base + ((v.ncells > 79) ? 79 : v.ncells);
        check("ld_count", ld_cnt, v.ncells);
        check("queue_left", exp_q.size(), 0);
        check("underrun_clean", int'(o_underrun), 0);
        check("last_txt_addr", int'(o_txt_addr), last);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            txt_mem[i]  = 8'(i * 37 + 65);
            font_mem[i] = 8'((i * 13 + 7) ^ (i >> 4));
        end
        font_mem[12'h415] = 8'h18;

        tbl[0] = '{row: 2,  fl: 5,  lead: 8,  ncells: 2,  exp_base: 160};
        tbl[1] = '{row: 0,  fl: 5,  lead: 8,  ncells: 2,  exp_base: 0};
        tbl[2] = '{row: 31, fl: 3,  lead: 10, ncells: 3,  exp_base: 2320};
        tbl[3] = '{row: 29, fl: 15, lead: 8,  ncells: 2,  exp_base: 2320};
        tbl[4] = '{row: 7,  fl: 9,  lead: 8,  ncells: 80, exp_base: 560};

        i_rst_n = 1'b0; i_line_start = 1'b0; i_row = '0; i_font_line = '0; i_de = 1'b1;
        #7;
        check("rst_txt_addr", int'(o_txt_addr), 0);
        check("rst_font_addr", int'(o_font_addr), 0);
        check("rst_sh_data", int'(o_sh_data), 0);
        check("rst_sh_ld", int'(o_sh_ld), 0);
        check("rst_sh_cs", int'(o_sh_cs), 0);
        check("rst_underrun", int'(o_underrun), 0);
        i_de = 1'b0;
        @(posedge i_clk); #1 i_rst_n = 1'b1;
        repeat (3) @(posedge i_clk);

        for (int t = 0; t < 5; t++) run_line(tbl[t]);

        // line_start lands on the load of cell 2; that load still shows the old line.
        ld_cnt = 0;
        push_line(3, 1, 3, 1'b0);
        push_line(4, 1, 2, 1'b0);
        pulse_ls(3, 1);
        repeat (6) @(posedge i_clk);
        @(posedge i_clk); #1 i_de = 1'b1;
        repeat (16) @(posedge i_clk);
        #1 i_row = 5'd4; i_line_start = 1'b1;
        @(posedge i_clk); #1 i_line_start = 1'b0;
        repeat (23) @(posedge i_clk);
        #1 i_de = 1'b0;
        repeat (16) @(negedge i_clk);
        check("coll_ld_count", ld_cnt, 5);
        check("coll_queue_left", exp_q.size(), 0);
        check("coll_underrun", int'(o_underrun), 0);
        exp_q.delete();

        // i_de two cycles after line_start: first load finds the buffer empty.
        ld_cnt = 0;
        push_line(5, 4, 3, 1'b1);
        pulse_ls(5, 4);
        @(negedge i_clk);
        check("ur_before", int'(o_underrun), 0);
        @(posedge i_clk); #1 i_de = 1'b1;
        repeat (24) @(posedge i_clk);
        #1 i_de = 1'b0;
        repeat (16) @(negedge i_clk);
        check("ur_flag", int'(o_underrun), 1);
        check("ur_ld_count", ld_cnt, 3);
        check("ur_queue_left", exp_q.size(), 0);
        check("ur_last_addr", int'(o_txt_addr), 402);
        exp_q.delete();

        // Reset lands in F_WAIT of the first fetch of a line.
        ld_cnt = 0;
        pulse_ls(1, 2);
        repeat (4) @(posedge i_clk);
        #1 i_rst_n = 1'b0; i_de = 1'b1;
        #1;
        check("mid_rst_txt_addr", int'(o_txt_addr), 0);
        check("mid_rst_font_addr", int'(o_font_addr), 0);
        check("mid_rst_sh_data", int'(o_sh_data), 0);
        check("mid_rst_sh_ld", int'(o_sh_ld), 0);
        check("mid_rst_sh_cs", int'(o_sh_cs), 0);
        check("mid_rst_underrun", int'(o_underrun), 0);
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        repeat (24) @(posedge i_clk);
        @(negedge i_clk);
        check("post_rst_ld_count", ld_cnt, 0);
        check("post_rst_txt_addr", int'(o_txt_addr), 0);
        check("post_rst_font_addr", int'(o_font_addr), 0);
        check("post_rst_sh_cs", int'(o_sh_cs), 0);
        @(posedge i_clk); #1 i_de = 1'b0;
        repeat (4) @(posedge i_clk);

        run_line(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
